// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for a MIPS-style pipeline.
//
// A multiply or divide issued from E latches its operands and runs a
// fixed-length busy window (MUL_CYC or DIV_CYC cycles). The result lands
// in HI/LO on the edge where the window closes. mthi/mtlo write HI/LO
// directly with no busy time. While busy, further starts are ignored.
//
// Ports:
//   clk       in   pipeline clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   E-stage strobe: instruction in E is a mul/div-class op
//   md_op     in   [2:0] 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   src_a     in   [31:0] forwarded rs value
//   src_b     in   [31:0] forwarded rt value
//   md_use_D  in   instruction in D touches the mul/div unit
//   busy      out  multiply or divide in progress
//   stall_md  out  freeze PC/D and clear E (combinational)
//   hi        out  [31:0] HI register
//   lo        out  [31:0] LO register

module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Registered state
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [1:0]    r_op;     // only ops 0..3 are ever latched
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    // Next-state values
    logic [CW-1:0] w_cnt_next;
    logic [31:0]   w_a_next;
    logic [31:0]   w_b_next;
    logic [1:0]    w_op_next;
    logic [31:0]   w_hi_next;
    logic [31:0]   w_lo_next;

    state_t        w_state;

    // Datapath on the latched operands only, so HI/LO never see src_a/src_b
    // combinationally except through the mthi/mtlo register write.
    logic          w_unsigned;
    logic [63:0]   w_ext_a;
    logic [63:0]   w_ext_b;
    logic [63:0]   w_prod;
    logic          w_neg_a;
    logic          w_neg_b;
    logic [31:0]   w_mag_a;
    logic [31:0]   w_mag_b;
    logic [31:0]   w_q_mag;
    logic [31:0]   w_r_mag;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;

    assign w_state    = (r_cnt == '0) ? IDLE : RUN;
    assign w_unsigned = r_op[0];

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product of
    // the extended operands is the correct signed or unsigned result.
    assign w_ext_a = w_unsigned ? {32'd0, r_a} : {{32{r_a[31]}}, r_a};
    assign w_ext_b = w_unsigned ? {32'd0, r_b} : {{32{r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide via magnitudes: this avoids the 0x80000000 / -1
    // overflow corner, which naturally yields quotient 0x80000000, rem 0.
    assign w_neg_a = ~w_unsigned & r_a[31];
    assign w_neg_b = ~w_unsigned & r_b[31];
    assign w_mag_a = w_neg_a ? (~r_a + 32'd1) : r_a;
    assign w_mag_b = w_neg_b ? (~r_b + 32'd1) : r_b;
    assign w_q_mag = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
    assign w_r_mag = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
    assign w_quot  = (w_neg_a ^ w_neg_b) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = w_neg_a ? (~w_r_mag + 32'd1) : w_r_mag;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_a   <= w_a_next;
            r_b   <= w_b_next;
            r_op  <= w_op_next;
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_cnt_next = r_cnt;
        w_a_next   = r_a;
        w_b_next   = r_b;
        w_op_next  = r_op;
        w_hi_next  = r_hi;
        w_lo_next  = r_lo;

        case (w_state)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            w_a_next   = src_a;
                            w_b_next   = src_b;
                            w_op_next  = md_op[1:0];
                            w_cnt_next = CW'(MUL_CYC);
                        end
                        OP_DIV, OP_DIVU: begin
                            w_a_next   = src_a;
                            w_b_next   = src_b;
                            w_op_next  = md_op[1:0];
                            w_cnt_next = CW'(DIV_CYC);
                        end
                        OP_MTHI: w_hi_next = src_a;
                        OP_MTLO: w_lo_next = src_a;
                        default: ;  // 6-7: no state change
                    endcase
                end
            end
            RUN: begin
                // Starts are ignored here; the running op owns the unit.
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    if (!r_op[1]) begin
                        w_hi_next = w_prod[63:32];
                        w_lo_next = w_prod[31:0];
                    end else if (r_b != 32'd0) begin
                        // Divide by zero leaves HI/LO untouched.
                        w_lo_next = w_quot;
                        w_hi_next = w_rem;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy     = (w_state == RUN);
        // Gated by reset_n so the stall request is quiet while in reset.
        stall_md = reset_n & md_use_D & (start | busy);
        hi       = r_hi;
        lo       = r_lo;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed corner cases plus random traffic,
// checked by a scoreboard fed from a high-level reference model.

module tb_mdu_ctrl;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MUL_CYC(MUL_N), .DIV_CYC(DIV_N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t        scb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          m_rem = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural semantics of each op, expressed with plain arithmetic.
    task automatic model_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp, sq, sr;
        logic [63:0] up;
        e.len = 0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32]; m_lo = sp[31:0];
                e.len = MUL_N; e.name = "mult";
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
                e.len = MUL_N; e.name = "multu";
            end
            3'd2: begin
                if (b != 32'd0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0]; m_hi = sr[31:0];
                end
                e.len = DIV_N; e.name = "div";
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b; m_hi = a % b;
                end
                e.len = DIV_N; e.name = "divu";
            end
            3'd4: begin m_hi = a; e.name = "mthi"; end
            3'd5: begin m_lo = a; e.name = "mtlo"; end
            default: e.name = "nop";
        endcase
        if (op <= 3'd5) begin
            e.hi = m_hi;
            e.lo = m_lo;
            scb.push_back(e);
            m_rem = e.len;
        end
    endtask

    // One pipeline cycle: drive inputs, check busy/stall before the edge,
    // then advance the model across the edge.
    task automatic step(input logic s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic u);
        @(negedge clk);
        #2;
        start = s; md_op = op; src_a = a; src_b = b; md_use_D = u;
        #1;
        chk("busy", busy, (m_rem > 0));
        chk("stall_md", stall_md, u && (s || (m_rem > 0)));
        $display("cyc t=%0t start=%0b op=%0d a=%08h b=%08h use_D=%0b busy=%0b stall=%0b hi=%08h lo=%08h",
                 $time, s, op, a, b, u, busy, stall_md, hi, lo);
        @(posedge clk);
        if (m_rem == 0) begin
            if (s) model_issue(op, a, b);
        end else begin
            m_rem--;
        end
    endtask

    task automatic idle(input int n, input logic u);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, u);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a completion is a busy falling edge, or a zero-latency
    // mthi/mtlo at the head of the queue while the unit is idle.
    logic prev_busy = 1'b0;
    int   run_len   = 0;

    task automatic pop_check(input int len);
        exp_t e;
        if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL completion: got result hi=%08h lo=%08h expected no pending op", hi, lo);
        end else begin
            e = scb.pop_front();
            chk({e.name, " hi"}, hi, e.hi);
            chk({e.name, " lo"}, lo, e.lo);
            chk({e.name, " busy_len"}, 64'(len), 64'(e.len));
            $display("done %s busy_len=%0d hi=%08h lo=%08h", e.name, len, hi, lo);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_busy = 1'b0;
                run_len   = 0;
            end else begin
                if (busy) run_len++;
                if (prev_busy && !busy) begin
                    pop_check(run_len);
                    run_len = 0;
                end else if (!busy && scb.size() > 0 && scb[0].len == 0) begin
                    pop_check(0);
                end
                prev_busy = busy;
            end
        end
    end

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        start = 1'b1; md_use_D = 1'b1; md_op = 3'd0;
        reset_n = 1'b0;
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        chk("rst stall_md", stall_md, 1'b0);
        m_rem = 0; m_hi = 32'd0; m_lo = 32'd0;
        scb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        start = 1'b0; md_use_D = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; start = 1'b1; md_op = 3'd0;
        src_a = 32'd0; src_b = 32'd0; md_use_D = 1'b1;
        #1;
        chk("init busy", busy, 1'b0);
        chk("init hi", hi, 32'd0);
        chk("init lo", lo, 32'd0);
        chk("init stall_md", stall_md, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        start = 1'b0; md_use_D = 1'b0;
        reset_n = 1'b1;

        // mult / multu
        step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MUL_N + 1, 1'b0);
        step(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(MUL_N + 1, 1'b0);

        // signed divide, -7 / 2, with D-stage hazard held high
        step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        idle(DIV_N + 1, 1'b1);

        // divu by zero leaves prior HI/LO
        step(1'b1, 3'd4, 32'h11, 32'd0, 1'b0);
        step(1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
        step(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
        idle(DIV_N + 1, 1'b0);

        // signed overflow corner
        step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N + 1, 1'b0);

        // collision: mult on busy cycle 3 of a div is ignored
        step(1'b1, 3'd3, 32'd1000, 32'd7, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 3'd0, 32'd5, 32'd6, 1'b1);
        idle(DIV_N - 2, 1'b0);

        // mthi / mtlo and the no-op codes
        step(1'b1, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        step(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0, 1'b0);
        step(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1);
        step(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);
        idle(2, 1'b0);

        // reset on busy cycle 4 of a mult: no late write-back
        step(1'b1, 3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0);
        idle(3, 1'b0);
        mid_reset();
        idle(MUL_N + 2, 1'b0);
        @(negedge clk);
        chk("post-rst hi", hi, 32'd0);
        chk("post-rst lo", lo, 32'd0);
        step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle(MUL_N + 1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                 pick(), pick(), 1'($urandom_range(0, 1)));
        end

        // drain
        for (int i = 0; i < 20 && scb.size() > 0; i++) idle(1, 1'b0);
        idle(1, 1'b0);
        chk("drain pending", 64'(scb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 start  input  1  E-stage strobe: the instruction in E is a multiply/divide-class op.
REQ-004 md_op  input  3  op select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 are no-op.
REQ-005 src_a  input  32  forwarded rs value from E.
REQ-006 src_b  input  32  forwarded rt value from E.
REQ-007 md_use_D  input  1  the instruction in D is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-008 busy  output  1  a multiply or divide is in progress.
REQ-009 stall_md  output  1  request to the stall unit to freeze PC/D and clear E.
REQ-010 hi  output  32  HI register value.
REQ-011 lo  output  32  LO register value.
REQ-012 MUL_CYC, default 5, meaning: busy cycles for mult/multu.
REQ-013 DIV_CYC, default 10, meaning: busy cycles for div/divu.

Function
REQ-014 The block SHALL hold a down-counter cnt wide enough for DIV_CYC; busy SHALL equal (cnt != 0).
REQ-015 States SHALL be IDLE (cnt==0) and RUN (cnt!=0); there are no other states.
REQ-016 In IDLE with start=1 and md_op in {0..3}, the block SHALL latch src_a, src_b and md_op at the edge, load cnt with MUL_CYC or DIV_CYC, and enter RUN.
REQ-017 In RUN, cnt SHALL decrement by 1 per cycle; busy SHALL be high for exactly N consecutive cycles following the start edge.
REQ-018 On the edge where cnt goes 1->0, hi/lo SHALL update from the latched operands, so the result is visible in the cycle busy falls.
REQ-019 mult SHALL produce the signed 64-bit product and multu the unsigned 64-bit product: hi = bits [63:32], lo = bits [31:0].
REQ-020 div/divu SHALL produce signed/unsigned results: lo = quotient, hi = remainder; a signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-021 Divide by zero (latched src_b==0) SHALL leave hi and lo unchanged; busy timing SHALL be unaffected.
REQ-022 Signed div 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-023 With start=1 and md_op=4 (mthi) or 5 (mtlo) in IDLE, the block SHALL write src_a to hi or lo at the edge, with no busy cycles.
REQ-024 Any start while in RUN SHALL be ignored; the in-flight operation and its timing SHALL be unaffected.
REQ-025 start with md_op 6-7 SHALL change no state.
REQ-026 stall_md SHALL equal md_use_D && (start || busy), and SHALL be combinational.
REQ-027 hi and lo SHALL be registered outputs, with no combinational path from src_a or src_b.

Reset
REQ-028 When reset_n is low, asynchronously: cnt=0, hi=0, lo=0, latched operands=0, busy=0.
REQ-029 stall_md SHALL be 0 during reset, regardless of md_use_D and start.
REQ-030 A reset asserted during RUN SHALL abort the operation; hi and lo SHALL remain 0 and SHALL NOT take the pending result.
REQ-031 After reset_n rises, the first start edge SHALL be honoured normally.

Verification
REQ-032 mult: src_a=0xFFFFFFFE, src_b=3, start 1 cycle -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 div: src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 with prior hi=0x11, lo=0x22 -> hi and lo unchanged after 10 cycles.
REQ-034 Hazard: start div, md_use_D=1 throughout -> stall_md=1 on the start cycle and all 10 busy cycles, then 0; with md_use_D=0 -> stall_md=0 throughout.
REQ-035 Collision: a second start (mult) issued on busy cycle 3 of a div -> ignored; busy falls after 10 total cycles with the div result.
REQ-036 mthi 0x12345678 in IDLE -> hi=0x12345678 on the next edge and busy stays 0; mtlo likewise updates lo.
REQ-037 Reset: reset_n low on busy cycle 4 of a mult -> busy=0 and hi=lo=0 immediately; no late write-back after reset_n rises.
